// File: rtl/gate_exer_pkg.sv
// Shared types and golden gate function for the gate exerciser.
package gate_exer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } gateState_t;

  localparam int NUM_VEC = 4;

  // Expected {and, or, not(A)} for vec = {A, B}.
  function automatic logic [2:0] expectedGates(input logic [1:0] vec);
    return {vec[1] & vec[0], vec[1] | vec[0], ~vec[1]};
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the two-input gate unit.
module gate_ref_model
  import gate_exer_pkg::*;
(
  input  logic [1:0] iVec,
  output logic [2:0] oGold
);

  assign oGold = expectedGates(iVec);

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps A/B through all four vectors, checks the gate unit's AND/OR/NOT and
// reports pass/fail. Optional macro GATE_EXER_LOOP_EN makes runs repeat forever.
module gate_exerciser
  import gate_exer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iAnd,
  input  logic             iOr,
  input  logic             iNot,
  output logic             oA,
  output logic             oB,
  output logic             oBusy,
  output logic             oDone,
  output logic             oPass,
  output logic [ERR_W-1:0] oErrCnt,
  output logic [1:0]       oFailVec,
  output logic [2:0]       oFailBits
);

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);
  localparam logic [1:0]        VEC_LAST    = 2'(NUM_VEC - 1);

  gateState_t        stateReg, stateNext;
  logic [1:0]        vecReg, vecNext;
  logic [PASS_W-1:0] passReg, passNext;
  logic [SET_W-1:0]  settleReg, settleNext;
  logic [ERR_W-1:0]  errReg, errNext;
  logic [1:0]        failVecReg, failVecNext;
  logic [2:0]        failBitsReg, failBitsNext;
  logic              failSeenReg, failSeenNext;

  logic [2:0] goldBits;
  logic [2:0] sampledBits;
  logic [2:0] mismatchBits;
  logic       anyMismatch;
  logic       startRun;

  gate_ref_model uRefModel (
    .iVec  (vecReg),
    .oGold (goldBits)
  );

  assign sampledBits = {iAnd, iOr, iNot};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gMismatch
      assign mismatchBits[gi] = sampledBits[gi] ^ goldBits[gi];
    end
  endgenerate

  assign anyMismatch = |mismatchBits;

  always_comb begin
    stateNext    = stateReg;
    vecNext      = vecReg;
    passNext     = passReg;
    settleNext   = settleReg;
    errNext      = errReg;
    failVecNext  = failVecReg;
    failBitsNext = failBitsReg;
    failSeenNext = failSeenReg;
    startRun     = 1'b0;

    case (stateReg)
      IDLE: begin
        startRun = iStart;
      end

      SETTLE: begin
        settleNext = settleReg + 1'b1;
        if (settleReg == SETTLE_LAST) begin
          stateNext = CHECK;
        end
      end

      CHECK: begin
        if (anyMismatch) begin
          if (errReg != ERR_MAX) begin
            errNext = errReg + 1'b1;
          end
          if (!failSeenReg) begin
            failSeenNext = 1'b1;
            failVecNext  = vecReg;
            failBitsNext = mismatchBits;
          end
        end
        if ((vecReg == VEC_LAST) && (passReg == PASS_LAST)) begin
          stateNext = DONE;
        end else begin
          vecNext    = vecReg + 2'd1;
          settleNext = '0;
          stateNext  = SETTLE;
          if (vecReg == VEC_LAST) begin
            passNext = passReg + 1'b1;
          end
        end
      end

      DONE: begin
`ifdef GATE_EXER_LOOP_EN
        startRun = 1'b1;
`else
        startRun = iStart;
`endif
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    if (startRun) begin
      stateNext  = SETTLE;
      vecNext    = 2'd0;
      passNext   = '0;
      settleNext = '0;
`ifndef GATE_EXER_LOOP_EN
      // In loop mode the error history spans runs and only reset clears it.
      errNext      = '0;
      failVecNext  = '0;
      failBitsNext = '0;
      failSeenNext = 1'b0;
`endif
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      stateReg    <= IDLE;
      vecReg      <= 2'd0;
      passReg     <= '0;
      settleReg   <= '0;
      errReg      <= '0;
      failVecReg  <= 2'd0;
      failBitsReg <= 3'd0;
      failSeenReg <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      vecReg      <= vecNext;
      passReg     <= passNext;
      settleReg   <= settleNext;
      errReg      <= errNext;
      failVecReg  <= failVecNext;
      failBitsReg <= failBitsNext;
      failSeenReg <= failSeenNext;
    end
  end

  // oA/oB come straight from the vector register, so they are glitch-free.
  assign oA        = vecReg[1];
  assign oB        = vecReg[0];
  assign oBusy     = (stateReg == SETTLE) || (stateReg == CHECK);
  assign oDone     = (stateReg == DONE);
  assign oPass     = (stateReg == DONE) && (errReg == '0);
  assign oErrCnt   = errReg;
  assign oFailVec  = failVecReg;
  assign oFailBits = failBitsReg;

endmodule
